// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronized and debounced column read, one code per press.
// Optional macro KEYPAD_NUM_BUF_EN adds a 4-digit BCD entry buffer on num_out.
module keypad_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] num_out
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT);
  localparam logic [DW-1:0] REL_LAST = DW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    col_meta_r, col_sync_r;
  logic [1:0]    row_idx_r, row_idx_s;
  logic [3:0]    row_s;
  logic [CW-1:0] dwell_r, dwell_s;
  logic [DW-1:0] deb_r, deb_s;
  logic [3:0]    cand_r, cand_s;
  logic [1:0]    col_idx_r, col_idx_s;
  logic [3:0]    code_s;
  logic          valid_s, held_s;

  // Lowest-index low column wins when several are pressed together.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

  // Next-state and output logic for the scan/debounce/hold sequencer.
  always_comb begin
    state_s   = state_r;
    row_idx_s = row_idx_r;
    row_s     = row;
    dwell_s   = dwell_r;
    deb_s     = deb_r;
    cand_s    = cand_r;
    col_idx_s = col_idx_r;
    code_s    = key_code;
    valid_s   = 1'b0;
    held_s    = key_held;
    case (state_r)
      SCAN: begin
        if (dwell_r == DIV_LAST) begin
          dwell_s = {CW{1'b0}};
          if (col_sync_r != 4'hF) begin
            cand_s    = col_sync_r;
            col_idx_s = low_col(col_sync_r);
            deb_s     = {DW{1'b0}};
            state_s   = DEBOUNCE;
          end else begin
            row_idx_s = row_idx_r + 2'd1;
            row_s     = {row[2:0], row[3]};
          end
        end else begin
          dwell_s = dwell_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DEBOUNCE: begin
        if (col_sync_r != cand_r) begin
          dwell_s = {CW{1'b0}};
          state_s = SCAN;
        end else if (deb_r == DEB_LAST) begin
          code_s  = {row_idx_r, col_idx_r};
          valid_s = 1'b1;
          held_s  = 1'b1;
          deb_s   = {DW{1'b0}};
          state_s = HOLD;
        end else begin
          deb_s = deb_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        // deb_r doubles as the release counter here.
        if (col_sync_r != 4'hF) begin
          deb_s = {DW{1'b0}};
        end else if (deb_r == REL_LAST) begin
          held_s    = 1'b0;
          deb_s     = {DW{1'b0}};
          dwell_s   = {CW{1'b0}};
          row_idx_s = row_idx_r + 2'd1;
          row_s     = {row[2:0], row[3]};
          state_s   = SCAN;
        end else begin
          deb_s = deb_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        dwell_s   = {CW{1'b0}};
        deb_s     = {DW{1'b0}};
        row_idx_s = 2'd0;
        row_s     = 4'b1110;
        held_s    = 1'b0;
        state_s   = SCAN;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= SCAN;
      row_idx_r <= 2'd0;
      row       <= 4'b1110;
      dwell_r   <= {CW{1'b0}};
      deb_r     <= {DW{1'b0}};
      cand_r    <= 4'hF;
      col_idx_r <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_r   <= state_s;
      row_idx_r <= row_idx_s;
      row       <= row_s;
      dwell_r   <= dwell_s;
      deb_r     <= deb_s;
      cand_r    <= cand_s;
      col_idx_r <= col_idx_s;
      key_code  <= code_s;
      key_valid <= valid_s;
      key_held  <= held_s;
    end
  end

`ifdef KEYPAD_NUM_BUF_EN
  logic [15:0] num_r, num_s;

  // Entry-buffer edit: digits shift in, B deletes the last digit, C clears.
  always_comb begin
    num_s = num_r;
    if (valid_s) begin
      case (code_s)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: num_s = {num_r[11:0], code_s};
        4'hB:                         num_s = {4'h0, num_r[15:4]};
        4'hC:                         num_s = 16'h0000;
        default:                      num_s = num_r;
      endcase
    end else begin
      num_s = num_r;
    end
  end

  // Entry-buffer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) num_r <= 16'h0000;
    else        num_r <= num_s;
  end

  assign num_out = num_r;
`else
  assign num_out = 16'h0000;
`endif

endmodule
